// File: rtl/ct_ciu_vb_mb_entry.sv
// ct_ciu_vb_mb_entry: one multi-beat victim-buffer slot of the CIU write-back path.
// Holds a line's AW attributes plus NBEAT data beats, sequences AW / W / B, and
// compares the held line index against NSNP snoop lookup ports.
module ct_ciu_vb_mb_entry #(
  parameter int AW_WIDTH = 68,
  parameter int MID_W    = 3,
  parameter int BEAT_W   = 128,
  parameter int NBEAT    = 4,
  parameter int NSRC     = 4,
  parameter int NSNP     = 3,
  parameter int IDX_LSB  = 6,
  parameter int IDX_W    = 8
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  input  logic                     create_vld,
  input  logic [AW_WIDTH-1:0]      create_awbus,
  input  logic [MID_W-1:0]         create_mid,
  input  logic [NSRC-1:0]          src_wvld,
  input  logic [NSRC*BEAT_W-1:0]   src_wdata,
  input  logic                     aw_grant,
  input  logic                     w_grant,
  input  logic                     bresp_vld,
  input  logic [NSNP*IDX_W-1:0]    snp_index,
  output logic                     entry_free,
  output logic                     aw_req,
  output logic [AW_WIDTH-1:0]      awbus,
  output logic [MID_W-1:0]         mid,
  output logic [1:0]               offset,
  output logic                     w_req,
  output logic [BEAT_W-1:0]        w_data,
  output logic                     w_last,
  output logic [NSNP-1:0]          snp_hit,
  output logic                     err
);

  localparam int LOG_NB = $clog2(NBEAT);
  // One extra bit so the fill counter can reach NBEAT without wrapping.
  localparam int CNT_W  = LOG_NB + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_WAIT_B
  } state_e;

  state_e                state_q, state_d;
  logic [AW_WIDTH-1:0]   awbus_q;
  logic [MID_W-1:0]      mid_q;
  logic                  aw_pend_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [BEAT_W-1:0]     beat_q [NBEAT];
  logic                  err_q;

  logic [BEAT_W-1:0]     sel_data;
  logic                  src_any;
  logic                  src_multi;
  logic                  create_ok;
  logic                  fill_ok;
  logic                  fill_done;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  w_req_int;
  logic                  w_last_int;
  logic                  bresp_ok;
  logic                  err_set;

  // Source arbitration: lowest-indexed valid source supplies the beat.
  always_comb begin
    sel_data  = '0;
    src_any   = |src_wvld;
    src_multi = |(src_wvld & (src_wvld - NSRC'(1)));
    // Descending scan so the lowest set index is the last (winning) write.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_wvld[i]) sel_data = src_wdata[i*BEAT_W +: BEAT_W];
    end
  end

  // Qualified events and protocol-error detection.
  always_comb begin
    w_req_int  = (state_q == ST_DRAIN) && !aw_pend_q;
    w_last_int = (rd_cnt_q == LAST_CNT);
    create_ok  = create_vld && (state_q == ST_IDLE);
    fill_ok    = src_any && (state_q == ST_FILL);
    fill_done  = fill_ok && (wr_cnt_q == LAST_CNT);
    aw_fire    = aw_grant && aw_pend_q;
    w_fire     = w_grant && w_req_int;
    bresp_ok   = bresp_vld && (state_q == ST_WAIT_B);
    err_set    = (create_vld && (state_q != ST_IDLE))
               | (src_any && (state_q != ST_FILL))
               | (fill_ok && src_multi)
               | (aw_grant && !aw_pend_q)
               | (w_grant && !w_req_int)
               | (bresp_vld && (state_q != ST_WAIT_B));
  end

  // Next-state logic for the entry lifecycle.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (create_ok) state_d = ST_FILL;
      ST_FILL:   if (fill_done) state_d = ST_DRAIN;
      ST_DRAIN:  if (w_fire && w_last_int) state_d = ST_WAIT_B;
      ST_WAIT_B: if (bresp_ok) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!cpurst_b) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Attribute, AW-pending, counter and sticky-error registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      awbus_q   <= '0;
      mid_q     <= '0;
      aw_pend_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (create_ok) begin
        awbus_q  <= create_awbus;
        mid_q    <= create_mid;
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end else begin
        if (fill_ok) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (w_fire)  rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (create_ok)    aw_pend_q <= 1'b1;
      else if (aw_fire) aw_pend_q <= 1'b0;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Beat storage, written at the fill pointer.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    // NOTE: the beat array is reset because w_data must read zero out of reset and
    // a reset mid-fill must discard partial beats.
    if (!cpurst_b) begin
      for (int b = 0; b < NBEAT; b++) beat_q[b] <= '0;
    end else if (fill_ok) begin
      beat_q[wr_cnt_q[LOG_NB-1:0]] <= sel_data;
    end
  end

  // Snoop index compare; the only input-to-output combinational path.
  always_comb begin
    snp_hit = '0;
    for (int k = 0; k < NSNP; k++) begin
      snp_hit[k] = (state_q != ST_IDLE) &&
                   (snp_index[k*IDX_W +: IDX_W] == awbus_q[IDX_LSB +: IDX_W]);
    end
  end

  assign entry_free = (state_q == ST_IDLE);
  assign aw_req     = aw_pend_q;
  assign awbus      = awbus_q;
  assign mid        = mid_q;
  assign offset     = awbus_q[5:4];
  assign w_req      = w_req_int;
  assign w_data     = beat_q[rd_cnt_q[LOG_NB-1:0]];
  assign w_last     = w_last_int;
  assign err        = err_q;

endmodule
